// File: rtl/adder_issue_stage.sv
`timescale 1ns/1ps
// Operand-issue stage in front of an external combinational adder: a small operand FIFO
// feeding the adder plus a valid/ready result register. Optional overflow counter: ADDER_ISSUE_OVF_CNT_EN.
module adder_issue_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_ISSUE_OVF_CNT_EN
  ,
  input  logic             ovf_clr,
  output logic [15:0]      ovf_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] x_mem   [DEPTH];
  logic [WIDTH-1:0] y_mem   [DEPTH];
  logic             cin_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;

  logic head_valid;
  logic push;
  logic load;

  // Handshake decisions depend only on registered state, so out_ready never reaches in_ready.
  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q != FULL);
  assign push       = in_valid & in_ready;
  assign load       = head_valid & (~out_valid_q | out_ready);

  assign add_x   = head_valid ? x_mem[rd_ptr_q]   : '0;
  assign add_y   = head_valid ? y_mem[rd_ptr_q]   : '0;
  assign add_cin = head_valid ? cin_mem[rd_ptr_q] : 1'b0;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

  // Operand storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      x_mem[wr_ptr_q]   <= in_x;
      y_mem[wr_ptr_q]   <= in_y;
      cin_mem[wr_ptr_q] <= in_cin;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
      out_sum_d   = add_s;
      out_cout_d  = add_cout;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
    end
  end

`ifdef ADDER_ISSUE_OVF_CNT_EN
  logic [15:0] ovf_count_q, ovf_count_d;

  // Clear wins over a same-cycle overflowing load.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_count_d = '0;
    end else if (load && add_cout && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_adder_issue_stage.sv
`timescale 1ns/1ps
// Directed and random checks of adder_issue_stage against a reference adder and a
// cycle model of FIFO occupancy / result-register valid, with an expected-result queue.
module tb_adder_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x, in_y;
  logic        in_cin;
  logic [15:0] add_x, add_y;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
`ifdef ADDER_ISSUE_OVF_CNT_EN
  logic        ovf_clr;
  logic [15:0] ovf_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] sb[$];
  int          m_cnt;
  bit          m_ov;

  always #5 clk = ~clk;

  // Reference for the external combinational adder.
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {16'b0, add_cin};

  adder_issue_stage #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_cin    (in_cin),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADDER_ISSUE_OVF_CNT_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] x, input logic [15:0] y, input bit c);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_cin   = c;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic step(output bit acc);
    logic [16:0] exp;
    bit          ld;
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("in_ready", {31'b0, in_ready}, {31'b0, (m_cnt != 4)});
    if (m_cnt == 0) begin
      check("add_idle", {15'b0, add_cin, add_x}, 32'h0);
      check("add_idle_y", {16'b0, add_y}, 32'h0);
    end
    acc = in_valid && (m_cnt != 4);
    ld  = (m_cnt != 0) && (!m_ov || out_ready);
    if (m_ov && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", {31'b0, out_valid}, 32'h0);
      end else begin
        exp = sb.pop_front();
        check("result", {15'b0, out_cout, out_sum}, {15'b0, exp});
        $display("result %05h expected %05h", {out_cout, out_sum}, exp);
      end
    end
    if (acc) sb.push_back({1'b0, in_x} + {1'b0, in_y} + {16'b0, in_cin});
    m_ov  = ld || (m_ov && !out_ready);
    m_cnt = m_cnt + int'(acc) - int'(ld);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) step(acc);
    check("drain_empty", sb.size(), 32'h0);
  endtask

  initial begin
    bit acc;
    int n_acc;
    int guard;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
`ifdef ADDER_ISSUE_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
    m_cnt = 0;
    m_ov  = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_add_x", {16'b0, add_x}, 32'h0);
    check("rst_out_sum", {15'b0, out_cout, out_sum}, 32'h0);
`ifdef ADDER_ISSUE_OVF_CNT_EN
    check("rst_ovf_count", {16'b0, ovf_count}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Overflow case and one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFD, 16'h0004, 1'b1);
    step(acc);
    check("ovf_accept", {31'b0, acc}, 32'h1);
    check("lat_not_yet", {31'b0, out_valid}, 32'h0);
    check("head_visible", {16'b0, add_x}, 32'hFFFD);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step(acc);
    check("lat_valid", {31'b0, out_valid}, 32'h1);
    check("ovf_sum", {16'b0, out_sum}, 32'h0002);
    check("ovf_cout", {31'b0, out_cout}, 32'h1);
`ifdef ADDER_ISSUE_OVF_CNT_EN
    check("ovf_count_one", {16'b0, ovf_count}, 32'h1);
`endif
    drain();

    // Back-pressure fill: DEPTH+1 accepted, then stall with stable output
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 16'(n_acc + 1), 16'(n_acc + 1), 1'b0);
      step(acc);
      if (acc) n_acc++;
      if (c >= 5) begin
        check("bp_in_ready", {31'b0, in_ready}, 32'h0);
        check("bp_hold_sum", {16'b0, out_sum}, 32'h0002);
      end
    end
    check("bp_accepted", n_acc, 32'd5);
    drain();

    // Streaming: one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
      step(acc);
      check("stream_accept", {31'b0, acc}, 32'h1);
      if (i > 0) check("stream_valid", {31'b0, out_valid}, 32'h1);
    end
    drain();

    // Random stall
    n_acc = 0;
    guard = 0;
    drive(1'b0, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
    while (n_acc < 100 && guard < 3000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step(acc);
      guard++;
      if (acc) begin
        n_acc++;
        drive(in_valid, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
      end
    end
    check("stall_accepted", n_acc, 32'd100);
    drain();

    // Reset mid-stream with 3 buffered and a held result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i + 3), 16'h0010, 1'b0);
      step(acc);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("mid_rst_add_x", {16'b0, add_x}, 32'h0);
    check("mid_rst_out_sum", {16'b0, out_sum}, 32'h0);
    sb.delete();
    m_cnt = 0;
    m_ov  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h0001, 16'h0001, 1'b0);
    step(acc);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step(acc);
    check("post_rst_sum", {15'b0, out_cout, out_sum}, 32'h0002);
    drain();

`ifdef ADDER_ISSUE_OVF_CNT_EN
    // Saturation of the overflow counter, then clear during an overflowing load
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ovf_saturated", {16'b0, ovf_count}, 32'hFFFF);
    check("ovf_bulk_idle", {31'b0, out_valid}, 32'h0);
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step(acc);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    ovf_clr = 1'b1;
    step(acc);
    ovf_clr = 1'b0;
    check("ovf_cleared", {16'b0, ovf_count}, 32'h0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
